// File: rtl/output_fifo_pkg.sv
// Shared constants and helpers for the output FIFO family.
// The LIMIT_W function gives the pointer/limit width including the wrap bit.
package output_fifo_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_ADDR_MSB  = 13;
  localparam int DEF_AF_MARGIN = 8;

  function automatic int LIMIT_W(input int addr_msb);
    return addr_msb + 2;
  endfunction

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port RAM with a registered, enable-gated read port.
// Intended to infer a single block RAM; no reset on the storage or read register.
module bram_sdp #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 14
) (
  input  logic              i_clk,
  input  logic              i_wrEn,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [WIDTH-1:0]  i_wrData,
  input  logic              i_rdEn,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output logic [WIDTH-1:0]  o_rdData
);

  logic [WIDTH-1:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge i_clk) begin
    if (i_wrEn) r_mem[i_wrAddr] <= i_wrData;
    if (i_rdEn) o_rdData <= r_mem[i_rdAddr];
  end

endmodule

// File: rtl/output_limit_buffer.sv
// FIFO whose reader can be bounded by software-registered output limits.
// Define OUTPUT_LIMIT_ALIGN_EN to commit only whole packets (up to the last wr_eop).
module output_limit_buffer
  import output_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_MSB  = DEF_ADDR_MSB,
  parameter int AF_MARGIN = DEF_AF_MARGIN
) (
  input  logic                         CLK,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             din,
  input  logic                         wr_en,
  input  logic                         wr_eop,
  output logic                         full,
  output logic                         almost_full,
  output logic [WIDTH-1:0]             dout,
  input  logic                         rd_en,
  output logic                         empty,
  input  logic                         mode_limit,
  input  logic                         reg_output_limit,
  output logic [LIMIT_W(ADDR_MSB)-1:0] output_limit,
  output logic                         output_limit_not_done
);

  localparam int AW = ADDR_MSB + 1;
  localparam int LW = LIMIT_W(ADDR_MSB);
  localparam logic [LW-1:0] DEPTH    = {1'b1, {AW{1'b0}}};
  localparam logic [LW-1:0] AF_LEVEL = DEPTH - LW'(AF_MARGIN);
  localparam logic [LW-1:0] ONE      = LW'(1);

  logic [LW-1:0]    r_wrPtr, r_rdPtr, r_fetchPtr, r_limPtr;
  logic [LW-1:0]    r_pending, r_outputLimit;
  logic             r_ramValid, r_outValid;
  logic [WIDTH-1:0] r_dout, w_ramData;

  logic [LW-1:0] w_count, w_wrInc, w_wrPtrNext, w_bound, w_commit, w_pendingNext;
  logic          w_full, w_wr, w_pop, w_notDone, w_accept;
  logic          w_outLoad, w_issue;

  // rd_ptr advances on pop, so words still in the read pipeline count as stored
  assign w_count     = r_wrPtr - r_rdPtr;
  assign w_full      = (w_count == DEPTH);
  assign w_wr        = wr_en & ~w_full;
  assign w_pop       = rd_en & r_outValid;
  assign w_wrInc     = {{(LW-1){1'b0}}, w_wr};
  assign w_wrPtrNext = r_wrPtr + w_wrInc;
  assign w_bound     = mode_limit ? r_limPtr : r_wrPtr;
  assign w_notDone   = mode_limit & (r_rdPtr != r_limPtr);
  assign w_accept    = reg_output_limit & mode_limit & ~w_notDone;

`ifdef OUTPUT_LIMIT_ALIGN_EN
  logic [LW-1:0] r_pendingEop;
  assign w_commit = r_pendingEop;
`else
  logic w_unusedEop;
  assign w_unusedEop = wr_eop;
  assign w_commit    = r_pending;
`endif

  assign w_pendingNext = w_accept ? (r_pending - w_commit + w_wrInc)
                                  : (r_pending + w_wrInc);

  // Two-stage read path: RAM read register, then the FWFT output register
  assign w_outLoad = r_ramValid & (~r_outValid | w_pop);
  assign w_issue   = (~r_ramValid | w_outLoad) & (r_fetchPtr != w_bound);

  bram_sdp #(
    .WIDTH  (WIDTH),
    .ADDR_W (AW)
  ) u_ram (
    .i_clk    (CLK),
    .i_wrEn   (w_wr),
    .i_wrAddr (r_wrPtr[AW-1:0]),
    .i_wrData (din),
    .i_rdEn   (w_issue),
    .i_rdAddr (r_fetchPtr[AW-1:0]),
    .o_rdData (w_ramData)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_fetchPtr <= '0;
      r_limPtr   <= '0;
    end else begin
      r_wrPtr <= w_wrPtrNext;
      if (w_pop)   r_rdPtr    <= r_rdPtr + ONE;
      if (w_issue) r_fetchPtr <= r_fetchPtr + ONE;
      // Tracking the post-write pointer makes a 0->1 switch freeze exactly at wr_ptr
      if (!mode_limit)   r_limPtr <= w_wrPtrNext;
      else if (w_accept) r_limPtr <= r_limPtr + w_commit;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_pending     <= '0;
      r_outputLimit <= '0;
    end else begin
      if (!mode_limit) r_pending <= '0;
      else             r_pending <= w_pendingNext;
      if (w_accept) r_outputLimit <= w_commit;
    end
  end

`ifdef OUTPUT_LIMIT_ALIGN_EN
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_pendingEop <= '0;
    end else if (!mode_limit) begin
      r_pendingEop <= '0;
    end else if (w_wr & wr_eop) begin
      r_pendingEop <= w_pendingNext;
    end else if (w_accept) begin
      r_pendingEop <= r_pendingEop - w_commit;
    end
  end
`endif

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_ramValid <= 1'b0;
      r_outValid <= 1'b0;
      r_dout     <= '0;
    end else begin
      if (w_issue)        r_ramValid <= 1'b1;
      else if (w_outLoad) r_ramValid <= 1'b0;
      if (w_outLoad) begin
        r_outValid <= 1'b1;
        r_dout     <= w_ramData;
      end else if (w_pop) begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign full                  = w_full;
  assign almost_full           = (w_count >= AF_LEVEL);
  assign empty                 = ~r_outValid;
  assign dout                  = r_dout;
  assign output_limit          = r_outputLimit;
  assign output_limit_not_done = w_notDone;

endmodule
